// File: rtl/jk_bank_arbiter_pkg.sv
// rtl/jk_bank_arbiter_pkg.sv - shared op codes, FSM states and J/K decode for the JK bank arbiter
package jk_bank_arbiter_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  // Returns {j, k} for a masked-in bit under the given operation.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_SET:  jk = 2'b10;
      OP_CLR:  jk = 2'b01;
      OP_TOG:  jk = 2'b11;
      OP_HOLD: jk = 2'b00;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_bank.sv
// rtl/jk_bank_arbiter_bank.sv - bank of WIDTH JK flip-flops with a shared enable
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic q_bit;

    // JK cell: D flip-flop fed by the JK next-state equation, gated by the shared enable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_bit <= 1'b0;
      end else if (en) begin
        q_bit <= (j[i] & ~q_bit) | (~k[i] & q_bit);
      end
    end

    assign q[i] = q_bit;
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sharing one JK bank between two requesters
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  output logic             ack0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             grant_id
);

  state_t           state;
  state_t           state_next;
  logic             rr_ptr;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic             take;
  logic             win;
  logic             bank_en;
  logic [WIDTH-1:0] bank_j;
  logic [WIDTH-1:0] bank_k;
  logic [1:0]       jk;

  // Winner when both request is the round-robin pointer; a lone requester always wins.
  assign win = (req0 & req1) ? rr_ptr : req1;
  assign jk  = op_to_jk(op_r);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore outputs; the illegal encoding falls back to IDLE with everything idle.
  always_comb begin
    state_next = ST_IDLE;
    take       = 1'b0;
    bank_en    = 1'b0;
    bank_j     = '0;
    bank_k     = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          take       = 1'b1;
          state_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy       = 1'b1;
        bank_en    = 1'b1;
        bank_j     = mask_r & {WIDTH{jk[1]}};
        bank_k     = mask_r & {WIDTH{jk[0]}};
        state_next = ST_ACK;
      end
      ST_ACK: begin
        busy       = 1'b1;
        ack0       = ~grant_id;
        ack1       = grant_id;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Grant latch in IDLE and round-robin pointer update when the ack is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
      op_r     <= OP_HOLD;
      mask_r   <= '0;
    end else begin
      if (take) begin
        grant_id <= win;
        op_r     <= win ? op1 : op0;
        mask_r   <= win ? mask1 : mask0;
      end
      if (state == ST_ACK) begin
        rr_ptr <= ~grant_id;
      end
    end
  end

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .en (bank_en),
    .j  (bank_j),
    .k  (bank_k),
    .q  (q)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - self-checking bench for jk_bank_arbiter with a transaction-level model
module tb_jk_bank_arbiter;
  import jk_bank_arbiter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] mask0, mask1;
  logic         ack0, ack1, busy, grant_id;
  logic [W-1:0] q;

  int tests  = 0;
  int failed = 0;

  // Reference model: remaining cycles of the current operation, grant, fairness pointer, bank value.
  int           m_left;
  bit           m_gid;
  bit           m_rr;
  logic [1:0]   m_op;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_q;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .mask0(mask0), .ack0(ack0),
    .req1(req1), .op1(op1), .mask1(mask1), .ack1(ack1),
    .q(q), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] cur, input logic [1:0] op,
                                            input logic [W-1:0] m);
    case (op)
      OP_SET:  return cur | m;
      OP_CLR:  return cur & ~m;
      OP_TOG:  return cur ^ m;
      default: return cur;
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_gid = 1'b0; m_rr = 1'b0; m_q = '0; m_op = 2'b00; m_mask = '0;
  endtask

  task automatic model_step();
    bit w;
    if (m_left == 0) begin
      if (req0 || req1) begin
        w      = (req0 && req1) ? m_rr : req1;
        m_gid  = w;
        m_op   = w ? op1 : op0;
        m_mask = w ? mask1 : mask0;
        m_left = 2;
      end
    end else if (m_left == 2) begin
      m_q    = apply_op(m_q, m_op, m_mask);
      m_left = 1;
    end else begin
      m_rr   = ~m_gid;
      m_left = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic serve(input bit who, input logic [1:0] op, input logic [W-1:0] m,
                       output int acks, output int ack_t);
    acks = 0; ack_t = 0;
    if (who) begin req1 = 1'b1; op1 = op; mask1 = m; end
    else     begin req0 = 1'b1; op0 = op; mask0 = m; end
    for (int t = 1; t <= 4; t++) begin
      tick();
      if ((who ? ack1 : ack0) === 1'b1) begin
        acks++; ack_t = t;
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int acks, ack_t;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00; mask0 = '0; mask1 = '0;
    tick(); tick();
    tests++; if (q !== 4'b0000) begin failed++; $display("FAIL reset_q got %b want 0000", q); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if ({ack0, ack1} !== 2'b00) begin failed++; $display("FAIL reset_ack got %b want 00", {ack0, ack1}); end
    tests++; if (grant_id !== 1'b0) begin failed++; $display("FAIL reset_grant got %b want 0", grant_id); end
    rst = 1'b0;
    tick();
    req0 = 1'b1; op0 = OP_SET; mask0 = 4'b1010;
    tick();
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL abort_in_apply got busy=%b want 1", busy); end
    rst = 1'b1; req0 = 1'b0;
    model_reset();
    #1;
    tests++; if ({q, busy, ack0, ack1} !== 7'b0000_000) begin
      failed++; $display("FAIL abort_outputs got q=%b busy=%b ack=%b%b want q=0000 busy=0 ack=00", q, busy, ack0, ack1);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    tests++; if ({ack0, ack1, busy} !== 3'b000) begin failed++; $display("FAIL abort_no_ack got ack=%b%b busy=%b want 000", ack0, ack1, busy); end
    serve(1'b0, OP_SET, 4'b1010, acks, ack_t);
    tests++; if (q !== 4'b1010) begin failed++; $display("FAIL set_after_reset got q=%b want 1010", q); end
    tests++; if (acks !== 1) begin failed++; $display("FAIL set_ack_count got %0d want 1", acks); end
    tests++; if (ack_t !== 2) begin failed++; $display("FAIL set_ack_latency got %0d want 2", ack_t); end
  endtask

  task automatic test_ops();
    logic [1:0]   ops  [4] = '{OP_TOG, OP_CLR, OP_HOLD, OP_SET};
    logic [W-1:0] msks [4] = '{4'b0110, 4'b1000, 4'b1111, 4'b0000};
    logic [W-1:0] exps [4] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100};
    int acks, ack_t;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, ops[i], msks[i], acks, ack_t);
      tests++; if (q !== exps[i]) begin failed++; $display("FAIL op%0d_q got %b want %b", i, q, exps[i]); end
      tests++; if (acks !== 1) begin failed++; $display("FAIL op%0d_ack got %0d want 1", i, acks); end
      tests++; if (q !== m_q) begin failed++; $display("FAIL op%0d_model got %b want %b", i, q, m_q); end
    end
  endtask

  task automatic test_contention();
    int t0, t1, first_g, n0, n1;
    do_reset();
    t0 = -1; t1 = -1; first_g = -1; n0 = 0; n1 = 0;
    req0 = 1'b1; op0 = OP_SET; mask0 = 4'b0001;
    req1 = 1'b1; op1 = OP_SET; mask1 = 4'b1000;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (busy === 1'b1 && first_g < 0) first_g = int'(grant_id);
      if (ack0 === 1'b1) begin n0++; t0 = t; req0 = 1'b0; end
      if (ack1 === 1'b1) begin n1++; t1 = t; req1 = 1'b0; end
    end
    tests++; if (first_g !== 0) begin failed++; $display("FAIL contention_first got %0d want 0", first_g); end
    tests++; if (t1 - t0 !== 3 || t0 < 0) begin failed++; $display("FAIL contention_spacing got ack0@%0d ack1@%0d want gap 3", t0, t1); end
    tests++; if (q !== 4'b1001) begin failed++; $display("FAIL contention_q got %b want 1001", q); end
    tests++; if (n0 !== 1 || n1 !== 1) begin failed++; $display("FAIL contention_acks got %0d/%0d want 1/1", n0, n1); end
  endtask

  task automatic test_fairness();
    int  grants;
    bit  prev_busy;
    int  last;
    do_reset();
    grants = 0; prev_busy = 1'b0; last = -1;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 40 && grants < 6; t++) begin
      op0 = 2'($urandom); mask0 = 4'($urandom); op1 = 2'($urandom); mask1 = 4'($urandom);
      tick();
      if (busy === 1'b1 && !prev_busy) begin
        tests++;
        if (int'(grant_id) !== grants % 2 || int'(grant_id) === last) begin
          failed++; $display("FAIL fairness_grant%0d got %b want %0d", grants, grant_id, grants % 2);
        end
        last = int'(grant_id);
        grants++;
      end
      prev_busy = (busy === 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    tests++; if (grants !== 6) begin failed++; $display("FAIL fairness_count got %0d want 6", grants); end
    tests++; if (q !== m_q) begin failed++; $display("FAIL fairness_q got %b want %b", q, m_q); end
  endtask

  task automatic test_input_stability();
    logic [W-1:0] want;
    int acks, rises;
    bit prev_busy;
    want = apply_op(m_q, OP_TOG, 4'b0011);
    acks = 0; rises = 0; prev_busy = 1'b0;
    req0 = 1'b1; op0 = OP_TOG; mask0 = 4'b0011;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) begin op0 = OP_CLR; mask0 = 4'b1111; req0 = 1'b0; end
      if (ack0 === 1'b1) acks++;
      if (busy === 1'b1 && !prev_busy) rises++;
      prev_busy = (busy === 1'b1);
    end
    tests++; if (q !== want) begin failed++; $display("FAIL stability_q got %b want %b", q, want); end
    tests++; if (acks !== 1) begin failed++; $display("FAIL stability_ack got %0d want 1", acks); end
    tests++; if (rises !== 1) begin failed++; $display("FAIL stability_ops got %0d want 1", rises); end
  endtask

  task automatic test_single();
    int acks;
    do_reset();
    acks = 0;
    req1 = 1'b1; op1 = OP_SET; mask1 = 4'b0100;
    tick();
    tests++; if ({busy, grant_id} !== 2'b11) begin failed++; $display("FAIL single_grant got busy=%b grant=%b want 1 1", busy, grant_id); end
    for (int t = 0; t < 3; t++) begin
      tick();
      if (ack1 === 1'b1) begin acks++; req1 = 1'b0; end
    end
    tests++; if (acks !== 1 || q !== 4'b0100) begin failed++; $display("FAIL single_done got acks=%0d q=%b want 1 0100", acks, q); end
  endtask

  task automatic test_random();
    logic [W+3:0] got, want;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      end else begin
        rst = 1'b0;
        if (ack0 === 1'b1) req0 = 1'b0; else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
        if (ack1 === 1'b1) req1 = 1'b0; else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
      end
      op0 = 2'($urandom); mask0 = 4'($urandom); op1 = 2'($urandom); mask1 = 4'($urandom);
      tick();
      got  = {q, ack0, ack1, busy, grant_id};
      want = {m_q, (m_left == 1) && !m_gid, (m_left == 1) && m_gid, m_left != 0, m_gid};
      tests++;
      if (got !== want) begin
        failed++; $display("FAIL random_c%0d got q/a0/a1/busy/gid=%b want %b", c, got, want);
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ops();
    test_contention();
    test_fairness();
    test_input_stability();
    test_single();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
